// File: rtl/rename_map_ckpt_if.sv
// Rename-stage bundle: rename request, registered rename result, commit ports and free count.
interface rename_map_ckpt_if #(
  parameter int ARCH_REG_WIDTH  = 5,
  parameter int PHYS_REG_WIDTH  = 6,
  parameter int NR_COMMIT_PORTS = 2
);
  logic                                      flush_i;
  logic                                      rename_valid_i;
  logic                                      rename_ready_o;
  logic                                      rename_we_i;
  logic [ARCH_REG_WIDTH-1:0]                 rename_rd_i;
  logic [ARCH_REG_WIDTH-1:0]                 rename_rs1_i;
  logic [ARCH_REG_WIDTH-1:0]                 rename_rs2_i;
  logic                                      out_valid_o;
  logic [PHYS_REG_WIDTH-1:0]                 out_prd_o;
  logic [PHYS_REG_WIDTH-1:0]                 out_prs1_o;
  logic [PHYS_REG_WIDTH-1:0]                 out_prs2_o;
  logic [PHYS_REG_WIDTH-1:0]                 out_prev_prd_o;
  logic [NR_COMMIT_PORTS-1:0]                commit_we_i;
  logic [NR_COMMIT_PORTS*PHYS_REG_WIDTH-1:0] commit_waddr_i;
  logic [PHYS_REG_WIDTH:0]                   free_count_o;

  modport master (
    output flush_i, rename_valid_i, rename_we_i, rename_rd_i, rename_rs1_i, rename_rs2_i,
           commit_we_i, commit_waddr_i,
    input  rename_ready_o, out_valid_o, out_prd_o, out_prs1_o, out_prs2_o, out_prev_prd_o,
           free_count_o
  );

  modport slave (
    input  flush_i, rename_valid_i, rename_we_i, rename_rd_i, rename_rs1_i, rename_rs2_i,
           commit_we_i, commit_waddr_i,
    output rename_ready_o, out_valid_o, out_prd_o, out_prs1_o, out_prs2_o, out_prev_prd_o,
           free_count_o
  );
endinterface

// File: rtl/rename_map_ckpt.sv
// Register rename unit: speculative map, lowest-index free-list allocation, committed map
// checkpoint that a flush copies back into the speculative map in a single cycle.
module rename_map_ckpt #(
  parameter int ARCH_REG_WIDTH  = 5,
  parameter int PHYS_REG_WIDTH  = 6,
  parameter int NR_COMMIT_PORTS = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  rename_map_ckpt_if.slave bus
);
  localparam int NR_ARCH = 2**ARCH_REG_WIDTH;
  localparam int NR_PHYS = 2**PHYS_REG_WIDTH;
  localparam int CW      = PHYS_REG_WIDTH + 1;

  typedef logic [ARCH_REG_WIDTH-1:0] arch_t;
  typedef logic [PHYS_REG_WIDTH-1:0] phys_t;

  phys_t              spec_map [NR_ARCH];
  phys_t              comm_map [NR_ARCH];
  phys_t              prev_tab [NR_PHYS];
  arch_t              arch_tab [NR_PHYS];
  logic [NR_PHYS-1:0] free_map;
  logic [CW-1:0]      free_cnt;

  logic  out_valid;
  phys_t out_prd, out_prs1, out_prs2, out_prev;

  phys_t              cw_addr [NR_COMMIT_PORTS];
  phys_t              comm_nxt [NR_ARCH];
  logic [NR_PHYS-1:0] freed_mask;
  logic [CW-1:0]      n_freed;
  logic [NR_PHYS-1:0] ref_mask;
  logic [NR_PHYS-1:0] restore_free;
  logic [CW-1:0]      restore_cnt;
  phys_t              alloc_idx;
  logic [NR_PHYS-1:0] alloc_mask;
  logic               need_alloc, ready, fire, alloc;

  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_port
    assign cw_addr[k] = bus.commit_waddr_i[k*PHYS_REG_WIDTH +: PHYS_REG_WIDTH];

    // Committing a register that sits in the free list means the pipeline lost track of it.
    a_commit_live: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.commit_we_i[k] && cw_addr[k] != '0 && free_map[cw_addr[k]]));
  end

  assign need_alloc = bus.rename_we_i && (bus.rename_rd_i != '0);
  assign ready      = !bus.flush_i && ((free_cnt != '0) || !need_alloc);
  assign fire       = bus.rename_valid_i && ready;
  assign alloc      = fire && need_alloc;

  // Descending scan so the last hit, and therefore the result, is the lowest free index.
  always_comb begin
    alloc_idx = '0;
    for (int i = NR_PHYS-1; i >= 1; i--) begin
      if (free_map[i]) alloc_idx = phys_t'(i);
    end
    alloc_mask            = '0;
    alloc_mask[alloc_idx] = alloc;
  end

  // Ports are walked in index order so the younger (higher) port wins a shared arch register.
  always_comb begin
    comm_nxt   = comm_map;
    freed_mask = '0;
    n_freed    = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (bus.commit_we_i[k] && cw_addr[k] != '0) begin
        comm_nxt[arch_tab[cw_addr[k]]] = cw_addr[k];
        if (prev_tab[cw_addr[k]] != '0) begin
          freed_mask[prev_tab[cw_addr[k]]] = 1'b1;
          n_freed = n_freed + CW'(1);
        end
      end
    end
  end

  // Flush rebuilds the free list from whatever the post-commit checkpoint still references.
  always_comb begin
    ref_mask = '0;
    for (int a = 0; a < NR_ARCH; a++) begin
      ref_mask[comm_nxt[a]] = 1'b1;
    end
    restore_free    = ~ref_mask;
    restore_free[0] = 1'b0;
    restore_cnt     = '0;
    for (int i = 0; i < NR_PHYS; i++) begin
      restore_cnt = restore_cnt + CW'(restore_free[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_map  <= '{default: '0};
      comm_map  <= '{default: '0};
      prev_tab  <= '{default: '0};
      arch_tab  <= '{default: '0};
      free_map  <= {{(NR_PHYS-1){1'b1}}, 1'b0};
      free_cnt  <= CW'(NR_PHYS-1);
      out_valid <= 1'b0;
      out_prd   <= '0;
      out_prs1  <= '0;
      out_prs2  <= '0;
      out_prev  <= '0;
    end else begin
      comm_map  <= comm_nxt;
      out_valid <= fire;
      if (bus.flush_i) begin
        spec_map <= comm_nxt;
        free_map <= restore_free;
        free_cnt <= restore_cnt;
      end else begin
        free_map <= (free_map & ~alloc_mask) | freed_mask;
        free_cnt <= free_cnt - CW'(alloc) + n_freed;
        if (alloc) begin
          spec_map[bus.rename_rd_i] <= alloc_idx;
          prev_tab[alloc_idx]       <= spec_map[bus.rename_rd_i];
          arch_tab[alloc_idx]       <= bus.rename_rd_i;
        end
      end
      if (fire) begin
        out_prd  <= alloc ? alloc_idx : '0;
        out_prev <= alloc ? spec_map[bus.rename_rd_i] : '0;
        out_prs1 <= spec_map[bus.rename_rs1_i];
        out_prs2 <= spec_map[bus.rename_rs2_i];
      end
    end
  end

  assign bus.rename_ready_o = ready;
  assign bus.out_valid_o    = out_valid;
  assign bus.out_prd_o      = out_prd;
  assign bus.out_prs1_o     = out_prs1;
  assign bus.out_prs2_o     = out_prs2;
  assign bus.out_prev_prd_o = out_prev;
  assign bus.free_count_o   = free_cnt;
endmodule
